// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// mmio_uart_tx_pkg : register map, STATUS bit layout and TX FSM encoding
// Rev 1.0
// ============================================================================
package mmio_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;

  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_BUSY   = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_CNT_LO = 4;
  localparam int STAT_CNT_HI = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : synchronous byte FIFO, push accepted when not full or popping
// Rev 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with TX FIFO
// Rev 1.0
// ============================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic        memRr,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  input  logic [3:0]  w_mask,
  input  logic [3:0]  r_mask,
  output logic [31:0] rdData,
  output logic        txd,
  output logic        busy
);
  import mmio_uart_tx_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic [1:0]    reg_off;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_div;
  logic [15:0]   div;
  logic [15:0]   div_merged;
  logic          overflow;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [3:0]    count4;

  tx_state_e     state;
  tx_state_e     state_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic [2:0]    bitcnt;
  logic [2:0]    bitcnt_n;
  logic [15:0]   baud_cnt;
  logic [15:0]   baud_n;
  logic [15:0]   cur_div;
  logic [15:0]   cur_div_n;
  logic          txd_n;
  logic          busy_n;
  logic          bit_end;

  // The full word is always returned, so the read lane mask carries no information.
  logic unused_ok;
  assign unused_ok = ^{r_mask, addr[1:0], wtData[31:16], w_mask[3:2]};

  always_comb begin
    hit        = ce && (addr[31:4] == BASE_ADDR[31:4]);
    reg_off    = addr[3:2];
    wr_txdata  = hit && we && (reg_off == REG_TXDATA);
    wr_status  = hit && we && (reg_off == REG_STATUS);
    wr_div     = hit && we && (reg_off == REG_BAUD_DIV);
    fifo_push  = wr_txdata && w_mask[0];
    div_merged = {w_mask[1] ? wtData[15:8] : div[15:8],
                  w_mask[0] ? wtData[7:0]  : div[7:0]};
    count4     = 4'(fifo_count);
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wtData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_div) div <= (div_merged == 16'd0) ? 16'd1 : div_merged;
      if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (wr_status && wtData[STAT_OVF])  overflow <= 1'b0;
    end
  end

  // Divisor is sampled once per frame so a mid-frame BAUD_DIV write waits.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bitcnt_n  = bitcnt;
    baud_n    = baud_cnt;
    cur_div_n = cur_div;
    txd_n     = txd;
    busy_n    = busy;
    fifo_pop  = 1'b0;
    bit_end   = (baud_cnt == cur_div - 16'd1);
    case (state)
      ST_IDLE: begin
        txd_n  = 1'b1;
        busy_n = 1'b0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_n   = fifo_dout;
          cur_div_n = div;
          bitcnt_n  = 3'd0;
          baud_n    = 16'd0;
          state_n   = ST_START;
          txd_n     = 1'b0;
          busy_n    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_n  = 16'd0;
          state_n = ST_DATA;
          txd_n   = shreg[0];
        end else begin
          baud_n  = baud_cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_n   = 16'd0;
          shreg_n  = {1'b0, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            state_n = ST_STOP;
            txd_n   = 1'b1;
          end else begin
            txd_n   = shreg[1];
          end
        end else begin
          baud_n   = baud_cnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_n  = 16'd0;
          state_n = ST_IDLE;
          txd_n   = 1'b1;
          busy_n  = 1'b0;
        end else begin
          baud_n  = baud_cnt + 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= 8'd0;
      bitcnt   <= 3'd0;
      baud_cnt <= 16'd0;
      cur_div  <= DEFAULT_DIV;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bitcnt   <= bitcnt_n;
      baud_cnt <= baud_n;
      cur_div  <= cur_div_n;
      txd      <= txd_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    rdData = 32'd0;
    if (hit && memRr) begin
      case (reg_off)
        REG_STATUS: begin
          rdData[STAT_CNT_HI:STAT_CNT_LO] = count4;
          rdData[STAT_OVF]                = overflow;
          rdData[STAT_BUSY]               = busy;
          rdData[STAT_EMPTY]              = fifo_empty;
          rdData[STAT_FULL]               = fifo_full;
        end
        REG_BAUD_DIV: rdData[15:0] = div;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_mmio_uart_tx : directed + randomized self-checking bench for mmio_uart_tx
// Rev 1.0
// ============================================================================
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_DIV = BASE + 32'd8;
  localparam logic [31:0] A_RSV = BASE + 32'd12;
  localparam int          DEPTH = 8;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        ce     = 1'b0;
  logic        we     = 1'b0;
  logic        memRr  = 1'b0;
  logic [31:0] addr   = 32'd0;
  logic [31:0] wtData = 32'd0;
  logic [3:0]  w_mask = 4'd0;
  logic [3:0]  r_mask = 4'd0;
  logic [31:0] rdData;
  logic        txd;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .memRr  (memRr),
    .addr   (addr),
    .wtData (wtData),
    .w_mask (w_mask),
    .r_mask (r_mask),
    .rdData (rdData),
    .txd    (txd),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; wtData = d; w_mask = m;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0; w_mask = 4'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; memRr = 1'b1; addr = a; r_mask = 4'hF;
    #1;
    d = rdData;
    ce = 1'b0; memRr = 1'b0;
  endtask

  // Line level k cycles into a frame: start bit, 8 data bits LSB first, stop bit.
  function automatic logic line_level(input logic [7:0] data, input int div, input int k);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    return frame[k / div];
  endfunction

  task automatic run_frame(input logic [7:0] data, input int div, input string tag,
                           output int waited);
    waited = 0;
    while (busy !== 1'b1 && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, " start"}, 32'(busy), 32'd1);
    if (busy !== 1'b1) return;
    for (int k = 0; k < 10 * div; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("%s txd[%0d]", tag, k), 32'(txd), 32'(line_level(data, div, k)));
      check($sformatf("%s busy[%0d]", tag, k), 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle txd"}, 32'(txd), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          w;
    int          w0;
    int          dv;
    int          nacc;
    logic [7:0]  b;
    logic [7:0]  b2;
    logic [7:0]  bytes [10];
    logic [7:0]  exp_q [$];

    repeat (3) @(posedge clk);
    #1;
    check("reset txd", 32'(txd), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    bus_read(A_ST, rd);  check("reset status", rd, 32'h0000_0002);
    bus_read(A_DIV, rd); check("reset div", rd, 32'h0000_0364);
    bus_read(A_TX, rd);  check("txdata read", rd, 32'd0);
    bus_read(A_RSV, rd); check("reserved read", rd, 32'd0);
    @(negedge clk);
    ce = 1'b1; memRr = 1'b0; addr = A_DIV;
    #1;
    check("no memRr read", rdData, 32'd0);
    ce = 1'b0;

    // Lane 1 only: low byte of the divisor is kept.
    bus_write(A_DIV, 32'hABCD_0500, 4'b0010);
    bus_read(A_DIV, rd); check("div lane1", rd, 32'h0000_0564);
    bus_write(A_TX, 32'h0000_0077, 4'b1110);
    bus_read(A_ST, rd); check("tx no lane0", rd, 32'h0000_0002);

    bus_write(A_DIV, 32'd4, 4'hF);
    bus_write(A_TX, 32'h0000_0055, 4'h1);
    run_frame(8'h55, 4, "f55", w);
    check("f55 latency", 32'(w), 32'd1);

    for (int i = 0; i < 3; i++) begin
      dv = int'($urandom_range(1, 6));
      b  = 8'($urandom);
      bus_write(A_DIV, 32'(dv), 4'hF);
      bus_write(A_TX, {24'd0, b}, 4'h1);
      run_frame(b, dv, $sformatf("rnd%0d", i), w);
      check($sformatf("rnd%0d latency", i), 32'(w), 32'd1);
    end

    // Ten back-to-back pushes while idle: head pops at once, DEPTH more fit.
    bus_write(A_DIV, 32'd4, 4'hF);
    for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
    nacc = (10 <= DEPTH + 1) ? 10 : DEPTH + 1;
    exp_q.delete();
    for (int i = 0; i < nacc; i++) exp_q.push_back(bytes[i]);
    fork
      run_frame(exp_q[0], 4, "b2b0", w0);
      begin
        for (int i = 0; i < 10; i++) bus_write(A_TX, {24'd0, bytes[i]}, 4'h1);
        bus_read(A_ST, rd);
        check("b2b status", rd, {24'd0, 4'(nacc - 1), 1'b1, 1'b1, 1'b0, 1'b1});
        bus_write(A_ST, 32'h0000_0008, 4'hF);
        bus_read(A_ST, rd);
        check("ovf cleared", rd, {24'd0, 4'(nacc - 1), 1'b0, 1'b1, 1'b0, 1'b1});
      end
    join
    void'(exp_q.pop_front());
    for (int i = 1; exp_q.size() > 0; i++) begin
      b = exp_q.pop_front();
      run_frame(b, 4, $sformatf("b2b%0d", i), w);
    end
    bus_read(A_ST, rd); check("b2b drained", rd, 32'h0000_0002);

    bus_write(A_DIV, 32'd0, 4'h3);
    bus_read(A_DIV, rd); check("div zero->1", rd, 32'h0000_0001);
    bus_write(A_TX, 32'h0000_00A3, 4'h1);
    run_frame(8'hA3, 1, "fA3", w);
    check("fA3 latency", 32'(w), 32'd1);

    // Divisor change while a frame is on the line.
    bus_write(A_DIV, 32'd4, 4'hF);
    b  = 8'($urandom);
    b2 = 8'($urandom);
    fork
      run_frame(b, 4, "mid0", w0);
      begin
        bus_write(A_TX, {24'd0, b}, 4'h1);
        repeat (12) @(posedge clk);
        bus_write(A_DIV, 32'd8, 4'hF);
        bus_write(A_TX, {24'd0, b2}, 4'h1);
      end
    join
    run_frame(b2, 8, "mid1", w);

    // Reset in the middle of a frame with a full FIFO and overflow set.
    bus_write(A_DIV, 32'd4, 4'hF);
    for (int i = 0; i < 10; i++) bus_write(A_TX, 32'($urandom_range(0, 255)), 4'h1);
    repeat (14) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid reset txd", 32'(txd), 32'd1);
    check("mid reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    bus_read(A_ST, rd);  check("mid reset status", rd, 32'h0000_0002);
    bus_read(A_DIV, rd); check("mid reset div", rd, 32'h0000_0364);

    bus_write(32'h2000_0000, 32'h0000_005A, 4'hF);
    bus_write(32'h2000_0008, 32'h0000_0002, 4'hF);
    bus_read(32'h2000_0004, rd); check("miss read", rd, 32'd0);
    bus_read(A_ST, rd);  check("miss status", rd, 32'h0000_0002);
    bus_read(A_DIV, rd); check("miss div", rd, 32'h0000_0364);
    repeat (3) @(posedge clk);
    #1;
    check("miss busy", 32'(busy), 32'd0);
    check("miss txd", 32'(txd), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
